alu_op_sequencer: RTL and testbench

- Multi-cycle command front end wrapped around the 32-bit ALU: sits directly upstream (drives operands and ALU control) and directly downstream (captures result and flags).
- Owns a small register bank and accepts one command at a time over a valid/ready interface.
- Returns each command's result over a valid/ready response interface.

---
 rtl/alu_op_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command front end for a 32-bit ALU: owns a register bank, issues one command at a time
// to the ALU and returns each result over a valid/ready response channel.
module alu_op_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [31:0]       cmd_imm,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [1:0]        alu_ctl,
    input  logic [31:0]       alu_r,
    input  logic              alu_zero,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_zero,
    output logic              rsp_cout,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] K_ALU   = 2'b00;
    localparam logic [1:0] K_LOADI = 2'b01;
    localparam logic [1:0] K_READ  = 2'b10;

    state_t            r_state;
    logic [31:0]       r_regs [NUM_REGS];
    logic [ADDR_W-1:0] r_rd;
    logic [31:0]       w_rs1_val;
    logic [31:0]       w_rs2_val;

    // r0 is never written, but masking the read keeps it zero regardless of bank contents.
    assign w_rs1_val = (cmd_rs1 == '0) ? 32'd0 : r_regs[cmd_rs1];
    assign w_rs2_val = (cmd_rs2 == '0) ? 32'd0 : r_regs[cmd_rs2];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // cmd_ready is high only in IDLE (and never while in reset); rsp_valid is high only
    // in RESP, and rsp_* stay stable until the edge that sees rsp_ready=1.
    assign cmd_ready = rst_n && (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rd     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctl  <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_cout <= 1'b0;
            rsp_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_kind)
                            K_ALU: begin
                                alu_a   <= w_rs1_val;
                                alu_b   <= w_rs2_val;
                                alu_ctl <= cmd_op;
                                r_rd    <= cmd_rd;
                                r_state <= EXEC;
                            end
                            K_LOADI: begin
                                if (cmd_rd != '0) begin
                                    r_regs[cmd_rd] <= cmd_imm;
                                end
                                rsp_data <= cmd_imm;
                                rsp_zero <= (cmd_imm == 32'd0);
                                rsp_cout <= 1'b0;
                                rsp_err  <= 1'b0;
                                r_state  <= RESP;
                            end
                            K_READ: begin
                                rsp_data <= w_rs1_val;
                                rsp_zero <= (w_rs1_val == 32'd0);
                                rsp_cout <= 1'b0;
                                rsp_err  <= 1'b0;
                                r_state  <= RESP;
                            end
                            default: begin
                                rsp_data <= '0;
                                rsp_zero <= 1'b0;
                                rsp_cout <= 1'b0;
                                rsp_err  <= 1'b1;
                                r_state  <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    rsp_data <= alu_r;
                    rsp_zero <= alu_zero;
                    rsp_cout <= alu_cout;
                    rsp_err  <= 1'b0;
                    if (r_rd != '0) begin
                        r_regs[r_rd] <= alu_r;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios followed by random commands, checked
// against a register-bank model and a scoreboard of expected responses.
module tb_alu_op_sequencer;

    localparam int EW = 35; // {err, cout, zero, data}

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_ctl;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_cout;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;
    logic        force_cout;
    logic [31:0] model_regs [8];
    logic [EW-1:0] exp_q [$];

    alu_op_sequencer #(.NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .dbg_state(dbg_state)
    );

    // Stub ALU; force_cout lets a test inject a carry regardless of the operation.
    logic [32:0] w_sum;
    assign w_sum = (alu_ctl == 2'b11) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                      : ({1'b0, alu_a} + {1'b0, alu_b});
    always_comb begin
        alu_r = w_sum[31:0];
        if (alu_ctl == 2'b00) alu_r = alu_a & alu_b;
        if (alu_ctl == 2'b01) alu_r = alu_a | alu_b;
    end
    assign alu_zero = (alu_r == 32'd0);
    assign alu_cout = (alu_ctl[1] & w_sum[32]) | force_cout;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [2:0] idx);
        return (idx == 3'd0) ? 32'd0 : model_regs[idx];
    endfunction

    // ---------------- driver ----------------
    task automatic do_cmd(input logic [1:0] kind, input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                          input int hold, input bit pulse);
        logic [31:0] a, b, d;
        logic        z, c, e;
        logic [63:0] wide;
        logic [EW-1:0] exp;
        int t, cyc, exp_lat;
        a = rd_model(rs1);
        b = rd_model(rs2);
        d = 32'd0; z = 1'b0; c = 1'b0; e = 1'b0;
        exp_lat = 1;
        case (kind)
            2'b00: begin
                exp_lat = 2;
                wide = {32'd0, a} + {32'd0, b};
                case (op)
                    2'b00: d = a & b;
                    2'b01: d = a | b;
                    2'b10: begin d = wide[31:0]; c = (wide > 64'hFFFF_FFFF); end
                    default: begin d = a - b; c = (a >= b); end
                endcase
                if (force_cout) c = 1'b1;
                z = (d == 32'd0);
                if (rd != 3'd0) model_regs[rd] = d;
            end
            2'b01: begin
                d = imm; z = (imm == 32'd0);
                if (rd != 3'd0) model_regs[rd] = imm;
            end
            2'b10: begin d = a; z = (a == 32'd0); end
            default: e = 1'b1;
        endcase
        exp_q.push_back({e, c, z, d});

        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1; cmd_kind = kind; cmd_op = op;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_kind = 2'($urandom); cmd_op = 2'($urandom); cmd_rd = 3'($urandom);
        cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom); cmd_imm = $urandom;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, exp_lat);
        exp = exp_q.pop_front();

        for (int h = 0; h < hold; h++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_data", rsp_data, exp[31:0]);
            check("hold_zero", {31'd0, rsp_zero}, {31'd0, exp[32]});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (pulse && h == 1) begin
                cmd_valid = 1'b1; cmd_kind = 2'b01; cmd_rd = 3'd1; cmd_imm = 32'hDEAD;
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end

        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", rsp_data, exp[31:0]);
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp[32]});
        check("rsp_cout", {31'd0, rsp_cout}, {31'd0, exp[33]});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp[34]});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_ctl"}, {30'd0, alu_ctl}, 32'd0);
        check({tag, "_rsp"}, {28'd0, rsp_valid, rsp_zero, rsp_cout, rsp_err}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kr, hold;
        logic [31:0] imm;
        tests_run = 0; tests_failed = 0;
        force_cout = 1'b0;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_kind = '0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Test 1: SUB via loaded registers
        do_cmd(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 32'd5, 0, 0);
        do_cmd(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 32'd3, 0, 0);
        do_cmd(2'b00, 2'b11, 3'd3, 3'd1, 3'd2, 32'd0, 0, 0);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd3, 3'd0, 32'd0, 0, 0);

        // Test 2: wrap to zero with carry, AND, then injected carry
        do_cmd(2'b01, 2'b00, 3'd4, 3'd0, 3'd0, 32'hFFFF_FFFF, 0, 0);
        do_cmd(2'b01, 2'b00, 3'd5, 3'd0, 3'd0, 32'd1, 0, 0);
        do_cmd(2'b00, 2'b10, 3'd6, 3'd4, 3'd5, 32'd0, 0, 0);
        do_cmd(2'b00, 2'b00, 3'd7, 3'd4, 3'd5, 32'd0, 0, 0);
        force_cout = 1'b1;
        do_cmd(2'b00, 2'b01, 3'd0, 3'd1, 3'd2, 32'd0, 0, 0);
        force_cout = 1'b0;

        // Test 3: stalled response with an ignored command pulse
        do_cmd(2'b00, 2'b11, 3'd1, 3'd1, 3'd1, 32'd0, 5, 1);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd1, 3'd0, 32'd0, 0, 0);

        // Test 4: r0 handling and rd == rs1 uses pre-write value
        do_cmd(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 32'd5, 0, 0);
        do_cmd(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 32'd3, 0, 0);
        do_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd0, 32'h1234, 0, 0);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0);
        do_cmd(2'b00, 2'b01, 3'd2, 3'd2, 3'd1, 32'd0, 0, 0);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd2, 3'd0, 32'd0, 0, 0);

        // Test 5: reserved kind, then a clean read
        do_cmd(2'b11, 2'b00, 3'd3, 3'd1, 3'd2, 32'hABCD, 0, 0);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd1, 3'd0, 32'd0, 0, 0);

        // Test 6: reset while in EXEC
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 2'b10;
        cmd_rd = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("exec_before_reset", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", {31'd0, cmd_ready}, 32'd1);
        do_cmd(2'b10, 2'b00, 3'd0, 3'd1, 3'd0, 32'd0, 0, 0);

        // Random phase
        for (int n = 0; n < 80; n++) begin
            kr = $urandom_range(0, 9);
            imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            hold = $urandom_range(0, 2);
            do_cmd((kr < 4) ? 2'b00 : (kr < 7) ? 2'b01 : (kr < 9) ? 2'b10 : 2'b11,
                   2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), imm, hold, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
